// File: rtl/ps2_direction_input_if.sv
// ps2_direction_input_if
//   Level-held key state presented by the PS/2 front end to the 2048 control FSM.
//   direction   : one-hot held arrow (0001 left, 0010 right, 0100 down, 1000 up, 0000 none)
//   start       : high while Enter is held
//   scan_code   : last valid received byte (debug)
//   scan_valid  : one-cycle pulse when scan_code updates
//   frame_error : one-cycle pulse on parity, stop-bit or timeout error
//   master = PS/2 front end (drives), slave = control FSM (samples)
interface ps2_direction_input_if;
    logic [3:0] direction;
    logic       start;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_error;

    modport master (
        output direction,
        output start,
        output scan_code,
        output scan_valid,
        output frame_error
    );

    modport slave (
        input direction,
        input start,
        input scan_code,
        input scan_valid,
        input frame_error
    );
endinterface

// File: rtl/ps2_direction_input.sv
// ps2_direction_input
//   PS/2 keyboard front end: receives device-to-host frames, decodes arrow and
//   Enter make/break sequences and holds direction/start for the control FSM.
//   clock    : system clock, rising edge
//   reset    : synchronous, active-high
//   ps2_clk  : raw PS/2 clock pin (asynchronous)
//   ps2_data : raw PS/2 data pin (asynchronous)
//   ctl      : key state outputs (see ps2_direction_input_if)
module ps2_direction_input #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    ps2_direction_input_if.master         ctl
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    // Synchronizers; idle PS/2 lines are high, so reset to 1 to avoid a false fall.
    logic [2:0] clk_sync;
    logic [1:0] dat_sync;
    logic       fall;
    logic       rx_bit;

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    assign fall   = clk_sync[2] & ~clk_sync[1];
    assign rx_bit = dat_sync[1];

    // Frame receiver
    rx_state_t     state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          par, par_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          byte_ok, byte_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tcnt    <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            par     <= par_n;
            tcnt    <= tcnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        par_n     = par;
        tcnt_n    = tcnt;
        byte_ok   = 1'b0;
        byte_err  = 1'b0;
        if (state == S_IDLE) begin
            tcnt_n = '0;
            if (fall && !rx_bit) begin
                state_n   = S_DATA;
                bit_cnt_n = '0;
            end
        end else if (fall) begin
            // A fall on the terminal count wins over the timeout.
            tcnt_n = '0;
            case (state)
                S_DATA: begin
                    shift_n   = {rx_bit, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = S_PARITY;
                end
                S_PARITY: begin
                    par_n   = rx_bit;
                    state_n = S_STOP;
                end
                S_STOP: begin
                    if (rx_bit && (^{shift, par})) byte_ok  = 1'b1;
                    else                           byte_err = 1'b1;
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end else if (tcnt == T_LAST) begin
            state_n  = S_IDLE;
            byte_err = 1'b1;
            tcnt_n   = '0;
        end else begin
            tcnt_n = tcnt + 1'b1;
        end
    end

    // Received byte registers
    logic [7:0] code_q;
    logic       valid_q;
    logic       err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= byte_ok;
            err_q   <= byte_err;
            if (byte_ok) code_q <= shift;
        end
    end

    // Decoder
    logic       ext, brk;
    logic [3:0] dir_q;
    logic       start_q;
    logic [3:0] arrow_oh;

    always_comb begin
        arrow_oh = '0;
        case (code_q)
            8'h6B: arrow_oh = 4'b0001;
            8'h74: arrow_oh = 4'b0010;
            8'h72: arrow_oh = 4'b0100;
            8'h75: arrow_oh = 4'b1000;
            default: arrow_oh = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ext     <= 1'b0;
            brk     <= 1'b0;
            dir_q   <= '0;
            start_q <= 1'b0;
        end else if (valid_q) begin
            case (code_q)
                8'hE0: ext <= 1'b1;
                8'hF0: brk <= 1'b1;
                default: begin
                    if (ext && (arrow_oh != 4'b0000)) begin
                        // A break only releases the arrow currently held.
                        if (!brk)                dir_q <= arrow_oh;
                        else if (dir_q == arrow_oh) dir_q <= '0;
                    end else if (!ext && (code_q == 8'h5A)) begin
                        start_q <= ~brk;
                    end
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            endcase
        end
    end

    assign ctl.direction   = dir_q;
    assign ctl.start       = start_q;
    assign ctl.scan_code   = code_q;
    assign ctl.scan_valid  = valid_q;
    assign ctl.frame_error = err_q;

endmodule

// File: tb/tb_ps2_direction_input.sv
module tb_ps2_direction_input;

    localparam int T    = 200;
    localparam int HALF = 8;

    logic clock    = 1'b0;
    logic reset    = 1'b1;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    ps2_direction_input_if ctl ();

    ps2_direction_input #(.TIMEOUT_CYCLES(T)) dut (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ctl      (ctl.master)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Monitor
    int         cyc     = 0;
    int         sv_cnt  = 0;
    int         fe_cnt  = 0;
    int         sv_wide = 0;
    int         fe_wide = 0;
    int         both_hi = 0;
    int         sv_cyc  = 0;
    int         fe_cyc  = 0;
    int         low_cyc = 0;
    logic       sv_prev = 1'b0;
    logic       fe_prev = 1'b0;
    logic       sv_seen = 1'b0;
    logic [3:0] dir_at_sv, dir_after_sv;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (sv_seen) begin
            dir_after_sv = ctl.direction;
            sv_seen      = 1'b0;
        end
        if (ctl.scan_valid === 1'b1) begin
            sv_cnt++;
            sv_cyc    = cyc;
            dir_at_sv = ctl.direction;
            sv_seen   = 1'b1;
            if (sv_prev) sv_wide++;
        end
        if (ctl.frame_error === 1'b1) begin
            fe_cnt++;
            fe_cyc = cyc;
            if (fe_prev) fe_wide++;
        end
        if (ctl.scan_valid === 1'b1 && ctl.frame_error === 1'b1) both_hi++;
        sv_prev = (ctl.scan_valid === 1'b1);
        fe_prev = (ctl.frame_error === 1'b1);
    end

    // Reference model: key state derived from the byte stream
    logic       m_ext, m_brk, m_start;
    logic [3:0] m_dir;
    logic [7:0] m_code;

    function automatic logic [3:0] arrow_of(input logic [7:0] b);
        case (b)
            8'h6B:   return 4'b0001;
            8'h74:   return 4'b0010;
            8'h72:   return 4'b0100;
            8'h75:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic void model_reset();
        m_ext = 0; m_brk = 0; m_start = 0; m_dir = '0; m_code = '0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [3:0] oh;
        oh     = arrow_of(b);
        m_code = b;
        if (b == 8'hE0)      m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (m_ext && oh != 0) begin
                if (!m_brk) m_dir = oh;
                else if (m_dir == oh) m_dir = '0;
            end else if (!m_ext && b == 8'h5A) begin
                m_start = !m_brk;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic p;
        p = (~^b) ^ bad_par;
        return {~bad_stop, p, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(posedge clock);
            ps2_clk = 1'b0;
            low_cyc = cyc;
            repeat (HALF) @(posedge clock);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    // kind: 0 good, 1 wrong parity, 2 stop bit 0
    task automatic send_byte(input logic [7:0] b, input int kind);
        int sv0, fe0;
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_bits(mk_frame(b, kind == 1, kind == 2), 0, 10);
        repeat (2) @(negedge clock);
        if (kind == 0) model_byte(b);
        check("scan_valid_count", sv_cnt - sv0, (kind == 0) ? 1 : 0);
        check("frame_error_count", fe_cnt - fe0, (kind != 0) ? 1 : 0);
        check("scan_code", ctl.scan_code, m_code);
        check("direction", ctl.direction, m_dir);
        check("start", ctl.start, m_start);
        check("onehot", ($countones(ctl.direction) <= 1), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_direction"}, ctl.direction, 4'b0000);
        check({tag, "_start"}, ctl.start, 1'b0);
        check({tag, "_scan_code"}, ctl.scan_code, 8'h00);
        check({tag, "_scan_valid"}, ctl.scan_valid, 1'b0);
        check({tag, "_frame_error"}, ctl.frame_error, 1'b0);
    endtask

    initial begin
        int sv0, fe0, r, k;
        logic [7:0] codes [4];
        codes[0] = 8'h6B; codes[1] = 8'h74; codes[2] = 8'h72; codes[3] = 8'h75;
        model_reset();

        // Reset
        repeat (3) @(posedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_values("reset");

        // Up arrow make, with latency of scan_valid and direction
        send_byte(8'hE0, 0);
        send_byte(8'h75, 0);
        check("up_make_dir", ctl.direction, 4'b1000);
        check("up_make_dir_at_valid", dir_at_sv, 4'b0000);
        check("up_make_dir_next", dir_after_sv, 4'b1000);
        check("valid_latency_ok", ((sv_cyc - low_cyc) >= 2) && ((sv_cyc - low_cyc) <= 5), 1);

        // Up break
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);
        check("up_break_dir", ctl.direction, 4'b0000);

        // Two arrows held
        send_byte(8'hE0, 0); send_byte(8'h6B, 0);
        check("left_make", ctl.direction, 4'b0001);
        send_byte(8'hE0, 0); send_byte(8'h74, 0);
        check("right_make", ctl.direction, 4'b0010);
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h6B, 0);
        check("left_break_ignored", ctl.direction, 4'b0010);
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h74, 0);
        check("right_break", ctl.direction, 4'b0000);

        // Enter and bare arrow code
        send_byte(8'h5A, 0);
        check("enter_make", ctl.start, 1'b1);
        send_byte(8'hF0, 0); send_byte(8'h5A, 0);
        check("enter_break", ctl.start, 1'b0);
        send_byte(8'h75, 0);
        check("bare_75_dir", ctl.direction, 4'b0000);

        // Bad frames
        send_byte(8'h75, 1);
        send_byte(8'h75, 2);
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_bits(mk_frame(8'h75, 0, 0), 0, 4);
        repeat (T + 20) @(negedge clock);
        check("timeout_error_count", fe_cnt - fe0, 1);
        check("timeout_no_valid", sv_cnt - sv0, 0);
        check("timeout_delay_ok", ((fe_cyc - low_cyc) >= T + 1) && ((fe_cyc - low_cyc) <= T + 5), 1);
        check("timeout_dir", ctl.direction, m_dir);
        send_byte(8'hE0, 0); send_byte(8'h75, 0);
        check("after_errors_up", ctl.direction, 4'b1000);

        // Reset in the middle of a frame
        send_byte(8'hE0, 0); send_byte(8'h6B, 0);
        send_byte(8'hE0, 0);
        send_bits(mk_frame(8'h75, 0, 0), 0, 3);
        @(posedge clock);
        reset = 1'b1;
        @(posedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_values("midreset");
        model_reset();
        sv0 = sv_cnt;
        send_bits(mk_frame(8'h75, 0, 0), 4, 10);
        repeat (T + 30) @(negedge clock);
        check("midreset_no_valid", sv_cnt - sv0, 0);
        check("midreset_dir", ctl.direction, 4'b0000);
        send_byte(8'hE0, 0); send_byte(8'h75, 0);
        check("midreset_then_up", ctl.direction, 4'b1000);

        // Randomized key traffic
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 7);
            k = $urandom_range(0, 3);
            if (r <= 3) begin
                send_byte(8'hE0, 0);
                if ($urandom_range(0, 1) == 1) send_byte(8'hF0, 0);
                send_byte(codes[k], 0);
            end else if (r == 4) begin
                if ($urandom_range(0, 1) == 1) send_byte(8'hF0, 0);
                send_byte(8'h5A, 0);
            end else if (r == 5) begin
                send_byte(8'($urandom_range(0, 255)), 0);
            end else if (r == 6) begin
                send_byte(8'($urandom_range(0, 255)), $urandom_range(1, 2));
            end else begin
                send_byte(codes[k], 0);
            end
        end

        check("scan_valid_width", sv_wide, 0);
        check("frame_error_width", fe_wide, 0);
        check("valid_error_exclusive", both_hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_direction_input.md
# ps2_direction_input

PS/2 keyboard front end for the 2048 datapath. It receives raw PS/2 device-to-host frames, decodes the arrow-key and Enter make/break sequences, and drives the level-held one-hot `direction[3:0]` and `start` inputs of the game control FSM. It is the initiator side of the control block's `direction`/`start` interface and sits between the board pins and the control FSM.

## Interface
- `TIMEOUT_CYCLES`, 50000: number of `clock` cycles with no PS/2 falling edge that aborts a partial frame (about 1 ms at 50 MHz).
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `direction`  out  4  one-hot held direction: 0001 left, 0010 right, 0100 down, 1000 up, 0000 none.
- `start`  out  1  high while Enter is held.
- `scan_code`  out  8  last valid received byte, for debug.
- `scan_valid`  out  1  one-cycle pulse when `scan_code` updates.
- `frame_error`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- **Synchronizer**
  - `ps2_clk` and `ps2_data` each pass through 2 flops.
  - A third `ps2_clk` flop gives `fall` = previous 1 and current 0.
  - Data is sampled on the cycle `fall` is asserted.
- **Frame receiver states**
  - **IDLE:** on `fall` with data 0 (start bit), go to DATA and set bit count 0. On `fall` with data 1, stay in IDLE; this is not an error.
  - **DATA:** shift data LSB-first on each `fall`. After the 8th bit, go to PARITY.
  - **PARITY:** latch the bit and go to STOP.
  - **STOP:** on `fall`, accept the byte if the stop bit is 1 and odd parity holds (the 8 data bits plus the parity bit contain an odd number of 1s). Otherwise pulse `frame_error` and drop the byte. Return to IDLE either way.
- **Timeout**
  - A counter runs in every state except IDLE and clears on each `fall`.
  - When it reaches `TIMEOUT_CYCLES - 1`, go to IDLE, pulse `frame_error` and discard the partial byte.
  - The counter saturates and never wraps.
- **Decoder**
  - State is two flags, `ext` (0xE0 seen) and `brk` (0xF0 seen).
  - **0xE0:** set `ext`.
  - **0xF0:** set `brk`; `ext` is kept.
  - **Any other byte:** act on it as below, then clear `ext` and `brk`.
    - With `ext` = 1, arrow codes are 0x6B left, 0x74 right, 0x72 down, 0x75 up.
    - Make (`brk` = 0) loads `direction` with that arrow's one-hot value. The latest make wins; typematic repeats reload the same value.
    - Break (`brk` = 1) clears `direction` to 0000 only if the arrow matches the current `direction`. A break of a non-current arrow is ignored.
    - With `ext` = 0, 0x5A (Enter) make sets `start` and break clears it.
    - All other codes change no output apart from `scan_code`.
- **Output invariant:** `direction` is always 0000 or exactly one hot bit.

## Timing
- **Reset:** applies on any clock edge where `reset` is high, including mid-frame. Values after reset:
  - receiver in IDLE, timeout counter 0, `ext` = `brk` = 0;
  - `direction` = 0000, `start` = 0, `scan_code` = 0x00, `scan_valid` = 0, `frame_error` = 0.
- **Pin to `fall`:** 3 cycles from a pin edge to `fall`.
- **Accepted byte:** the stop-bit `fall` occurs in cycle N.
  - `scan_code` and `scan_valid` are registered at N+1.
  - `direction` and `start` update at N+2.
- **Rejected byte:** `frame_error` is high at N+1. `scan_valid`, `direction`, `start` and the decoder flags are unchanged.
- **Pulse width:** `scan_valid` and `frame_error` are exactly 1 cycle wide and are never high together.
- **Timeout vs `fall`:** if `fall` coincides with the terminal timeout count, `fall` wins and the counter clears.
- **Minimum input rate:** PS/2 clock (10–16.7 kHz) is always much slower than `clock`. Back-to-back bytes need no idle gap beyond one PS/2 bit period.
- **Hold behaviour:** outputs hold between bytes; the control FSM samples the levels.

## Test plan
- **Up arrow make:** send 0xE0 then 0x75 with correct parity.
  - `scan_valid` pulses twice, with `scan_code` 0xE0 then 0x75.
  - `direction` = 1000 two cycles after the second stop-bit `fall`.
- **Up break:** with `direction` = 1000, send 0xE0, 0xF0, 0x75 → `direction` = 0000.
- **Two arrows held:** send left make (E0 6B) → 0001; then right make (E0 74) → 0010.
  - Left break (E0 F0 6B) leaves 0010.
  - Right break (E0 F0 74) gives 0000.
- **Enter:** 0x5A gives `start` = 1. 0xF0 then 0x5A gives `start` = 0. Bare 0x75 (no E0) leaves `direction` unchanged.
- **Bad frames:** each gives `frame_error` one 1-cycle pulse, no `scan_valid`, and outputs unchanged.
  - 0x75 with wrong parity.
  - 0x75 with stop bit 0.
  - Frame stopped after 4 data bits; the error fires `TIMEOUT_CYCLES` cycles after the last `fall`.
  - A following good E0 75 still gives `direction` = 1000.
- **Reset mid-frame:** assert `reset` for 1 cycle after 3 data bits of an arrow make.
  - All outputs go to their reset values.
  - The remaining bits of that frame do not produce `scan_valid`.
  - The next complete E0 75 gives `direction` = 1000.
